// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder/subtractor with a valid/ready handshake.
// Each stage resolves SLICE_WIDTH*SLICES_PER_STAGE bits. Every slice precomputes
// its sum and carry-out for both carry-in values. The incoming carry then only
// ripples through the slice muxes. The stage carry is registered between stages.
module pipelined_carry_select_adder #(
    parameter int ADDER_WIDTH      = 32,
    parameter int SLICE_WIDTH      = 4,
    parameter int SLICES_PER_STAGE = 2
) (
    input  logic                   iClk,
    input  logic                   iRst_n,
    input  logic                   iValid,
    output logic                   oReady,
    input  logic [ADDER_WIDTH-1:0] iA,
    input  logic [ADDER_WIDTH-1:0] iB,
    input  logic                   iCarry,
    input  logic                   iSub,
    output logic                   oValid,
    input  logic                   iReady,
    output logic [ADDER_WIDTH-1:0] oSum,
    output logic                   oCarry,
    output logic                   oOvf
);

    localparam int GROUP_WIDTH = SLICE_WIDTH * SLICES_PER_STAGE;
    localparam int NUM_STAGES  = ADDER_WIDTH / GROUP_WIDTH;
    localparam int MSB         = ADDER_WIDTH - 1;

    // Reject geometries where the operand does not split evenly into stages
    if (SLICE_WIDTH < 1 || SLICES_PER_STAGE < 1 || (ADDER_WIDTH % GROUP_WIDTH) != 0) begin : g_bad_geometry
        $error("ADDER_WIDTH must be a multiple of SLICE_WIDTH*SLICES_PER_STAGE");
    end

    // Resolve one stage group: slices precompute both outcomes, then the carry selects
    function automatic logic [GROUP_WIDTH:0] resolve_group(
        input logic [GROUP_WIDTH-1:0] a,
        input logic [GROUP_WIDTH-1:0] b,
        input logic                   carry_in
    );
        logic                   carry;
        logic [GROUP_WIDTH-1:0] sum;
        logic [SLICE_WIDTH:0]   res0;
        logic [SLICE_WIDTH:0]   res1;
        carry = carry_in;
        sum   = '0;
        for (int j = 0; j < SLICES_PER_STAGE; j++) begin
            res0 = {1'b0, a[j*SLICE_WIDTH +: SLICE_WIDTH]} + {1'b0, b[j*SLICE_WIDTH +: SLICE_WIDTH]};
            res1 = {1'b0, a[j*SLICE_WIDTH +: SLICE_WIDTH]} + {1'b0, b[j*SLICE_WIDTH +: SLICE_WIDTH]}
                 + {{SLICE_WIDTH{1'b0}}, 1'b1};
            sum[j*SLICE_WIDTH +: SLICE_WIDTH] = carry ? res1[SLICE_WIDTH-1:0] : res0[SLICE_WIDTH-1:0];
            carry = carry ? res1[SLICE_WIDTH] : res0[SLICE_WIDTH];
        end
        return {carry, sum};
    endfunction

    logic                   en;
    logic [ADDER_WIDTH-1:0] b_eff;
    logic                   cin;

    logic [ADDER_WIDTH-1:0] in_a   [NUM_STAGES];
    logic [ADDER_WIDTH-1:0] in_b   [NUM_STAGES];
    logic [ADDER_WIDTH-1:0] in_sum [NUM_STAGES];
    logic [NUM_STAGES-1:0]  in_c;
    logic [NUM_STAGES-1:0]  in_v;

    logic [ADDER_WIDTH-1:0] a_q   [NUM_STAGES];
    logic [ADDER_WIDTH-1:0] a_d   [NUM_STAGES];
    logic [ADDER_WIDTH-1:0] b_q   [NUM_STAGES];
    logic [ADDER_WIDTH-1:0] b_d   [NUM_STAGES];
    logic [ADDER_WIDTH-1:0] sum_q [NUM_STAGES];
    logic [ADDER_WIDTH-1:0] sum_d [NUM_STAGES];
    logic [NUM_STAGES-1:0]  carry_q;
    logic [NUM_STAGES-1:0]  carry_d;
    logic [NUM_STAGES-1:0]  valid_q;
    logic [NUM_STAGES-1:0]  valid_d;
    logic                   ovf_q;
    logic                   ovf_d;

    // The whole pipe advances unless a finished result is waiting on downstream
    assign en     = iReady | ~valid_q[NUM_STAGES-1];
    assign oReady = en;
    assign oValid = valid_q[NUM_STAGES-1];
    assign oSum   = sum_q[NUM_STAGES-1];
    assign oCarry = carry_q[NUM_STAGES-1];
    assign oOvf   = ovf_q;

    // Operand prep: subtraction is A + ~B + 1, and the external carry is ignored
    always_comb begin
        b_eff = iSub ? ~iB : iB;
        cin   = iSub ? 1'b1 : iCarry;
    end

    // Gather each stage's source: stage 0 takes the prepared inputs, later stages the previous register
    always_comb begin
        in_a[0]   = iA;
        in_b[0]   = b_eff;
        in_sum[0] = '0;
        in_c[0]   = cin;
        in_v[0]   = iValid;
        for (int k = 1; k < NUM_STAGES; k++) begin
            in_a[k]   = a_q[k-1];
            in_b[k]   = b_q[k-1];
            in_sum[k] = sum_q[k-1];
            in_c[k]   = carry_q[k-1];
            in_v[k]   = valid_q[k-1];
        end
    end

    // Next state: every stage resolves its group, and data only loads behind a valid token so outputs hold across bubbles
    always_comb begin
        logic [GROUP_WIDTH:0] res;
        res     = '0;
        carry_d = carry_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        for (int k = 0; k < NUM_STAGES; k++) begin
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            sum_d[k] = sum_q[k];
        end
        if (en) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                res        = resolve_group(in_a[k][k*GROUP_WIDTH +: GROUP_WIDTH],
                                           in_b[k][k*GROUP_WIDTH +: GROUP_WIDTH], in_c[k]);
                valid_d[k] = in_v[k];
                if (in_v[k]) begin
                    a_d[k]                             = in_a[k];
                    b_d[k]                             = in_b[k];
                    sum_d[k]                           = in_sum[k];
                    sum_d[k][k*GROUP_WIDTH +: GROUP_WIDTH] = res[GROUP_WIDTH-1:0];
                    carry_d[k]                         = res[GROUP_WIDTH];
                    if (k == NUM_STAGES - 1) begin
                        ovf_d = (in_a[k][MSB] == in_b[k][MSB]) & (res[GROUP_WIDTH-1] != in_a[k][MSB]);
                    end
                end
            end
        end
    end

    // Stage registers; reset drops every in-flight transaction and clears the result
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
            carry_q <= '0;
            valid_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
            end
            carry_q <= carry_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Self-checking bench for pipelined_carry_select_adder: directed cases plus a randomized run against an arithmetic scoreboard.
module tb_pipelined_carry_select_adder;

    logic        iClk;
    logic        iRst_n;
    logic        iValid;
    logic        oReady;
    logic [31:0] iA;
    logic [31:0] iB;
    logic        iCarry;
    logic        iSub;
    logic        oValid;
    logic        iReady;
    logic [31:0] oSum;
    logic        oCarry;
    logic        oOvf;

    typedef struct packed {
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
    } exp_t;

    exp_t        expQ[$];
    int          errCount   = 0;
    int          checkCount = 0;
    int          cycleCount = 0;
    int          readyMode  = 0;
    int          stallStart = 0;
    logic        prevStall  = 1'b0;
    logic [31:0] prevSum    = '0;
    logic        prevCarry  = 1'b0;

    pipelined_carry_select_adder dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iValid (iValid),
        .oReady (oReady),
        .iA     (iA),
        .iB     (iB),
        .iCarry (iCarry),
        .iSub   (iSub),
        .oValid (oValid),
        .iReady (iReady),
        .oSum   (oSum),
        .oCarry (oCarry),
        .oOvf   (oOvf)
    );

    // 10 ns clock
    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // Count one comparison and report it if it does not match
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: plain 33-bit arithmetic on the prepared operands
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        exp_t        r;
        logic [31:0] beff;
        logic [32:0] total;
        beff    = sub ? ~b : b;
        total   = {1'b0, a} + {1'b0, beff} + {32'd0, (sub ? 1'b1 : cin)};
        r.sum   = total[31:0];
        r.carry = total[32];
        r.ovf   = (a[31] == beff[31]) && (total[31] != a[31]);
        return r;
    endfunction

    // Downstream ready pattern: 0 always ready, 1 random, 2 four-cycle stall window
    initial begin
        iReady = 1'b1;
        forever begin
            @(posedge iClk);
            #1;
            cycleCount++;
            case (readyMode)
                1:       iReady = ($urandom % 4) != 0;
                2:       iReady = !(cycleCount >= stallStart && cycleCount < stallStart + 4);
                default: iReady = 1'b1;
            endcase
        end
    end

    // Monitor on the falling edge: transfers here happen at the next rising edge
    always @(negedge iClk) begin
        exp_t e;
        if (!iRst_n) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stall_valid", {63'd0, oValid}, 64'd1);
                checkOutput("stall_sum", {32'd0, oSum}, {32'd0, prevSum});
                checkOutput("stall_carry", {63'd0, oCarry}, {63'd0, prevCarry});
            end
            if (oValid && !iReady) begin
                checkOutput("ready_stall", {63'd0, oReady}, 64'd0);
            end
            if (iValid && oReady) begin
                expQ.push_back(model(iA, iB, iCarry, iSub));
            end
            if (oValid && iReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_result", {32'd0, oSum}, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sum", {32'd0, oSum}, {32'd0, e.sum});
                    checkOutput("carry", {63'd0, oCarry}, {63'd0, e.carry});
                    checkOutput("ovf", {63'd0, oOvf}, {63'd0, e.ovf});
                end
            end
            prevStall = oValid && !iReady;
            prevSum   = oSum;
            prevCarry = oCarry;
        end
    end

    // Present one operand set and hold it until the adder accepts it
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        int waitCycles;
        @(posedge iClk);
        #1;
        iValid = 1'b1;
        iA     = a;
        iB     = b;
        iCarry = cin;
        iSub   = sub;
        waitCycles = 0;
        @(negedge iClk);
        while (!oReady && waitCycles < 1000) begin
            waitCycles++;
            @(negedge iClk);
        end
        if (!oReady) checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    // Insert one bubble
    task automatic idleCycle();
        @(posedge iClk);
        #1;
        iValid = 1'b0;
    endtask

    // Wait until every accepted transaction has come out
    task automatic drainPipe();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 500) begin
            @(negedge iClk);
            n++;
        end
        checkOutput("drain_left", 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        int lat;
        iRst_n = 1'b0;
        iValid = 1'b0;
        iA     = '0;
        iB     = '0;
        iCarry = 1'b0;
        iSub   = 1'b0;
        #2;
        checkOutput("reset_valid", {63'd0, oValid}, 64'd0);
        checkOutput("reset_sum", {32'd0, oSum}, 64'd0);
        checkOutput("reset_carry", {63'd0, oCarry}, 64'd0);
        checkOutput("reset_ovf", {63'd0, oOvf}, 64'd0);
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;
        @(negedge iClk);
        checkOutput("ready_after_reset", {63'd0, oReady}, 64'd1);

        // Latency: one add, then count cycles until the result is presented
        applyStimulus(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
        idleCycle();
        lat = 0;
        while (!oValid && lat < 20) begin
            @(negedge iClk);
            lat++;
        end
        checkOutput("latency", 64'(lat), 64'd4);
        drainPipe();

        // Carry through every stage, then the subtract flag cases
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        idleCycle();
        drainPipe();

        // Backpressure: eight back-to-back adds with a four-cycle output stall
        stallStart = cycleCount + 6;
        readyMode  = 2;
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(32'(i), 32'(i), 1'b0, 1'b0);
        end
        idleCycle();
        drainPipe();
        readyMode = 0;

        // Reset with three transactions in flight
        applyStimulus(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        applyStimulus(32'h0000_0030, 32'h0000_0040, 1'b0, 1'b0);
        applyStimulus(32'h0000_0050, 32'h0000_0060, 1'b0, 1'b0);
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        iRst_n = 1'b0;
        #1;
        checkOutput("midreset_valid", {63'd0, oValid}, 64'd0);
        checkOutput("midreset_sum", {32'd0, oSum}, 64'd0);
        expQ.delete();
        @(negedge iClk);
        iRst_n = 1'b1;
        repeat (10) @(negedge iClk);

        // Randomized operands, bubbles and downstream ready
        readyMode = 1;
        for (int n = 0; n < 10000; n++) begin
            if (($urandom % 4) == 0) idleCycle();
            applyStimulus($urandom, $urandom, 1'($urandom), 1'($urandom));
        end
        idleCycle();
        drainPipe();
        readyMode = 0;

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
